serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the team's 1-bit full adder cell `adder1_1`. Each cycle the block feeds one operand bit pair and the registered carry into a single `adder1_1` instance, LSB first, and collects the sum bits in a shift register. Upstream logic hands over full-width operands on a valid/ready handshake. The result is returned on a second valid/ready handshake. This trades WIDTH cycles of latency for one full-adder cell instead of a WIDTH-bit ripple chain.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is WIDTH ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands `a`, `b`, `cin` are valid.
- `in_ready`  out  1: block can accept operands; equals (state == IDLE).
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in for bit 0.
- `out_valid`  out  1: `sum` and `cout` hold a completed result.
- `out_ready`  in  1: consumer accepts the result.
- `sum`  out  WIDTH: registered result, equal to (a + b + cin) mod 2^WIDTH.
- `cout`  out  1: carry out of the MSB.
- `ovf`  out  1: signed overflow; this port exists only when `SERIAL_ADDER_OVF_EN` is defined.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On an edge with `in_valid`=1: load `a_sh`←a, `b_sh`←b, `carry`←cin, `cnt`←0, then go to RUN.
- **RUN**
  - `adder1_1` inputs are a_sh[0], b_sh[0] and `carry`.
  - Each edge:
    - `a_sh`/`b_sh` shift right.
    - `sum_sh` shifts right with the new sum bit inserted at its MSB.
    - `carry`←adder cout.
    - `cnt`++.
  - On the edge where `cnt` == WIDTH-1:
    - Load `sum`←final `sum_sh` value (including this bit).
    - Load `cout`←adder cout.
    - Go to DONE.
- **DONE**
  - `out_valid`=1; `sum`/`cout` are held stable.
  - On an edge with `out_ready`=1, go to IDLE.
  - While `out_ready`=0, remain in DONE indefinitely. `in_valid` is ignored because `in_ready`=0.
- Operand inputs are sampled only on the accepting edge. Changes to `a`/`b`/`cin` during RUN or DONE have no effect.
- `cnt` width is $clog2(WIDTH+1).
- With WIDTH=1, RUN lasts exactly one edge.
- `sum`/`cout` keep the last result after returning to IDLE. They are meaningful only while `out_valid`=1.
- Reset, including mid-RUN or mid-DONE:
  - Immediately state=IDLE and `in_ready`=1.
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, and all shift registers, `carry` and `cnt` cleared.
  - The aborted operation never produces `out_valid`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- Accept edge E0 (in_valid & in_ready).
- RUN occupies edges E1..E_WIDTH.
- `out_valid` rises after edge E_WIDTH, i.e. WIDTH edges after acceptance.
- The result handshake completes on the first edge with `out_ready`=1 while in DONE.
- `in_ready` returns to 1 in the cycle after that edge.
- Minimum operation period is WIDTH+2 cycles; operations do not overlap.
- `in_ready` and `out_valid` are pure decodes of the state register; there is no combinational path from any input to any output.

## Configuration
- Macro `SERIAL_ADDER_OVF_EN` defined:
  - Port `ovf` and one extra register are present.
  - On the final RUN edge, `ovf` ← (carry into MSB) XOR (carry out of MSB).
  - `ovf` is held with `sum` and reset to 0.
- Macro undefined:
  - No `ovf` port and no overflow register.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, out_ready=1 → `out_valid` rises exactly 8 edges after acceptance with sum=8'h10, cout=0; `in_ready`=1 one cycle later.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0 (macro defined); a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- With macro defined, a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → sum/cout stable, in_ready=0, new operands ignored; after the out_ready pulse the next accepted op gives the correct result.
- Drive rst_n low asynchronously during RUN after 3 bits → outputs immediately 0 and in_ready=1, out_valid never asserts for the aborted op; the next op a=8'h12, b=8'h34 → sum=8'h46.
- WIDTH=1: all 8 combinations of {a,b,cin} → {cout,sum} == a+b+cin, each result 1 edge after acceptance.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, valid/ready in and out.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output `ovf`.

module adder1_1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    adder1_1 u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    // New bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sum_nxt = (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    carry  <= c_bit;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= sum_nxt;
                        cout  <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ c_bit;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 table, corner sequences and
// random ops vs. an arithmetic model, plus an exhaustive WIDTH=1 instance.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, co8;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, cin1 = 1'b0, co1;
    logic [0:0] a1 = '0, b1 = '0, s1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       vf8, vf1;
`endif

    int passed = 0;
    int total  = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(vf8),
`endif
        .cout(co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1),
        .sum(s1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(vf1),
`endif
        .cout(co1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, output logic [7:0] s,
                        output logic co, output logic ov, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        a8 = ~a; b8 = ~b; cin8 = ~c;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        s = s8; co = co8;
`ifdef SERIAL_ADDER_OVF_EN
        ov = vf8;
`else
        ov = 1'b0;
`endif
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        chk("in_ready_after_handshake", {31'b0, ir8}, 32'd1);
    endtask

    task automatic run1(input logic a, input logic b, input logic c,
                        output logic s, output logic co, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
        @(posedge clk);
        #1 iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        s = s1[0]; co = co1;
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk);
        #1 or1 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0] rs, ea, eb, es;
        logic       rco, rov, ec, eco, eov, held_co;
        logic [8:0] full;
        int         lat, seen;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

        #2;
        chk("reset_in_ready", {31'b0, ir8}, 32'd1);
        chk("reset_out_valid", {31'b0, ov8}, 32'd0);
        chk("reset_sum", {24'b0, s8}, 32'd0);
        chk("reset_cout", {31'b0, co8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_ovf", {31'b0, vf8}, 32'd0);
`endif
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rco, rov, lat);
            chk($sformatf("tbl%0d_latency", i), lat, 32'd8);
            chk($sformatf("tbl%0d_sum", i), {24'b0, rs}, {24'b0, tbl[i].s});
            chk($sformatf("tbl%0d_cout", i), {31'b0, rco}, {31'b0, tbl[i].co});
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), {31'b0, rov}, {31'b0, tbl[i].ov});
`endif
        end

        // Stall in DONE while new operands are offered.
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h0A; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("stall_latency", lat, 32'd8);
        held_co = co8;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1; iv8 = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_sum", k), {24'b0, s8}, 32'h47);
            chk($sformatf("stall%0d_cout", k), {31'b0, co8}, {31'b0, held_co});
            chk($sformatf("stall%0d_in_ready", k), {31'b0, ir8}, 32'd0);
            chk($sformatf("stall%0d_out_valid", k), {31'b0, ov8}, 32'd1);
        end
        chk("stall_cout_value", {31'b0, held_co}, 32'd0);
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        chk("stall_release_in_ready", {31'b0, ir8}, 32'd1);
        run8(8'h21, 8'h13, 1'b0, rs, rco, rov, lat);
        chk("after_stall_sum", {24'b0, rs}, 32'h34);

        // Asynchronous reset three bits into RUN.
        @(negedge clk);
        a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'b0, ir8}, 32'd1);
        chk("abort_out_valid", {31'b0, ov8}, 32'd0);
        chk("abort_sum", {24'b0, s8}, 32'd0);
        chk("abort_cout", {31'b0, co8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_ovf", {31'b0, vf8}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (ov8) seen++;
        end
        chk("abort_never_valid", seen, 32'd0);
        run8(8'h12, 8'h34, 1'b0, rs, rco, rov, lat);
        chk("after_abort_sum", {24'b0, rs}, 32'h46);
        chk("after_abort_latency", lat, 32'd8);

        // Random operations against plain arithmetic.
        for (int i = 0; i < 40; i++) begin
            ea = 8'($urandom);
            eb = 8'($urandom);
            ec = 1'($urandom);
            full = 9'(ea) + 9'(eb) + 9'(ec);
            es = full[7:0];
            eco = full[8];
            eov = (ea[7] == eb[7]) && (es[7] != ea[7]);
            run8(ea, eb, ec, rs, rco, rov, lat);
            chk($sformatf("rnd%0d_latency", i), lat, 32'd8);
            chk($sformatf("rnd%0d_sum", i), {24'b0, rs}, {24'b0, es});
            chk($sformatf("rnd%0d_cout", i), {31'b0, rco}, {31'b0, eco});
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), {31'b0, rov}, {31'b0, eov});
`endif
        end

        // WIDTH=1: exhaustive.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            logic [1:0] exp2;
            bits = 3'(v);
            exp2 = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
            run1(bits[2], bits[1], bits[0], rs[0], rco, lat);
            chk($sformatf("w1_%0d_latency", v), lat, 32'd1);
            chk($sformatf("w1_%0d_result", v), {30'b0, rco, rs[0]},
                {30'b0, exp2});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
